// File: rtl/lbp_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_window_sequencer
//  Description : Address/strobe sequencer for a 3x3 LBP datapath over a fixed
//                128x128 8-bit gray image. Fetches a full window at each row
//                start and only the new right-hand column for later pixels,
//                then strobes one LBP result write per interior pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module lbp_window_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        gray_ready,
    output logic        gray_req,
    output logic [13:0] gray_addr,
    output logic        slot_wr,
    output logic [3:0]  slot_idx,
    output logic        win_shift,
    output logic        lbp_valid,
    output logic [13:0] lbp_addr,
    output logic        finish
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FULL  = 3'd1;
    localparam logic [2:0] S_PART  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [6:0] c_FIRST     = 7'd1;
    localparam logic [6:0] c_LAST      = 7'd126;
    localparam logic [3:0] c_FULL_LAST = 4'd8;
    localparam logic [3:0] c_PART_LAST = 4'd2;

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic [6:0]  r_row;
    logic [6:0]  r_col;

    logic [2:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [6:0]  w_row_nxt;
    logic [6:0]  w_col_nxt;

    logic        w_gray_req_nxt;
    logic [13:0] w_gray_addr_nxt;
    logic        w_slot_wr_nxt;
    logic [3:0]  w_slot_idx_nxt;
    logic        w_win_shift_nxt;
    logic        w_lbp_valid_nxt;
    logic [13:0] w_lbp_addr_nxt;
    logic        w_finish_nxt;

    logic [3:0]  w_rd_slot;
    logic [1:0]  w_dr;
    logic [1:0]  w_dc;
    logic [6:0]  w_rd_row;
    logic [6:0]  w_rd_col;

    // Window slot targeted by the read issued in a given state/count:
    // FULL walks slots 0..8, PART refills the right column (2, 5, 8).
    function automatic logic [3:0] f_slot(input logic [2:0] st, input logic [3:0] cnt);
        logic [3:0] v_slot;
        v_slot = 4'd0;
        if (st == S_FULL) begin
            v_slot = cnt;
        end else if (st == S_PART) begin
            case (cnt)
                4'd0:    v_slot = 4'd2;
                4'd1:    v_slot = 4'd5;
                default: v_slot = 4'd8;
            endcase
        end
        return v_slot;
    endfunction

    // State, counters and all outputs register together so every output is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_row     <= c_FIRST;
            r_col     <= c_FIRST;
            gray_req  <= 1'b0;
            gray_addr <= 14'd0;
            slot_wr   <= 1'b0;
            slot_idx  <= 4'd0;
            win_shift <= 1'b0;
            lbp_valid <= 1'b0;
            lbp_addr  <= 14'd0;
            finish    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            gray_req  <= w_gray_req_nxt;
            gray_addr <= w_gray_addr_nxt;
            slot_wr   <= w_slot_wr_nxt;
            slot_idx  <= w_slot_idx_nxt;
            win_shift <= w_win_shift_nxt;
            lbp_valid <= w_lbp_valid_nxt;
            lbp_addr  <= w_lbp_addr_nxt;
            finish    <= w_finish_nxt;
        end
    end

    // Next-state and raster-position update.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        case (r_state)
            S_IDLE: begin
                if (gray_ready) begin
                    w_state_nxt = S_FULL;
                    w_cnt_nxt   = 4'd0;
                    w_row_nxt   = c_FIRST;
                    w_col_nxt   = c_FIRST;
                end
            end
            S_FULL: begin
                if (r_cnt == c_FULL_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            S_PART: begin
                if (r_cnt == c_PART_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (r_col != c_LAST) begin
                    w_state_nxt = S_SHIFT;
                    w_col_nxt   = r_col + 7'd1;
                end else if (r_row != c_LAST) begin
                    // New row: refetch the whole window, no shift across rows.
                    w_state_nxt = S_FULL;
                    w_cnt_nxt   = 4'd0;
                    w_row_nxt   = r_row + 7'd1;
                    w_col_nxt   = c_FIRST;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_SHIFT: begin
                w_state_nxt = S_PART;
                w_cnt_nxt   = 4'd0;
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode for the coming cycle; slot_wr trails the read issued now.
    always_comb begin
        w_rd_slot = f_slot(w_state_nxt, w_cnt_nxt);
        w_dr      = 2'd0;
        w_dc      = 2'd0;
        case (w_rd_slot)
            4'd0:    begin w_dr = 2'd0; w_dc = 2'd0; end
            4'd1:    begin w_dr = 2'd0; w_dc = 2'd1; end
            4'd2:    begin w_dr = 2'd0; w_dc = 2'd2; end
            4'd3:    begin w_dr = 2'd1; w_dc = 2'd0; end
            4'd4:    begin w_dr = 2'd1; w_dc = 2'd1; end
            4'd5:    begin w_dr = 2'd1; w_dc = 2'd2; end
            4'd6:    begin w_dr = 2'd2; w_dc = 2'd0; end
            4'd7:    begin w_dr = 2'd2; w_dc = 2'd1; end
            default: begin w_dr = 2'd2; w_dc = 2'd2; end
        endcase
        // Centre is always 1..126, so the -1..+1 neighbours stay inside 0..127.
        w_rd_row = w_row_nxt + {5'd0, w_dr} - 7'd1;
        w_rd_col = w_col_nxt + {5'd0, w_dc} - 7'd1;

        w_gray_req_nxt  = (w_state_nxt == S_FULL) || (w_state_nxt == S_PART);
        w_gray_addr_nxt = w_gray_req_nxt ? {w_rd_row, w_rd_col} : 14'd0;
        w_slot_wr_nxt   = (r_state == S_FULL) || (r_state == S_PART);
        w_slot_idx_nxt  = w_slot_wr_nxt ? f_slot(r_state, r_cnt) : 4'd0;
        w_win_shift_nxt = (w_state_nxt == S_SHIFT);
        w_lbp_valid_nxt = (w_state_nxt == S_WRITE);
        w_lbp_addr_nxt  = w_lbp_valid_nxt ? {w_row_nxt, w_col_nxt} : 14'd0;
        w_finish_nxt    = (w_state_nxt == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_lbp_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lbp_window_sequencer
//  Description : Directed self-checking bench for lbp_window_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lbp_window_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic        slot_wr;
    logic [3:0]  slot_idx;
    logic        win_shift;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic        finish;

    logic [36:0] w_all;

    int n_vec = 0;
    int n_err = 0;

    lbp_window_sequencer u_dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .slot_wr    (slot_wr),
        .slot_idx   (slot_idx),
        .win_shift  (win_shift),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    assign w_all = {gray_req, gray_addr, slot_wr, slot_idx, win_shift,
                    lbp_valid, lbp_addr, finish};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next lbp_valid; cycles counted in negedges.
    task automatic wait_lbp(input int max, output int cyc, output logic [13:0] addr);
        cyc  = 0;
        addr = 14'd0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!lbp_valid && cyc < max);
        check("lbp_wait", {63'd0, lbp_valid}, 64'd1);
        addr = lbp_addr;
    endtask

    initial begin
        logic [13:0] exp_full [9];
        logic [13:0] exp_part [3];
        logic [3:0]  exp_pslot [3];
        logic [13:0] a;
        int          cyc;
        int          req_seen;
        int          npulse, last_lbp_cyc, fin_cyc, first_lbp_cyc, excl;
        logic [13:0] first_ga, first_lbp, last_lbp;
        bit          ga_seen;

        exp_full  = '{14'd0, 14'd1, 14'd2, 14'd128, 14'd129, 14'd130, 14'd256, 14'd257, 14'd258};
        exp_part  = '{14'd3, 14'd131, 14'd259};
        exp_pslot = '{4'd2, 4'd5, 4'd8};

        // Reset and idle behaviour.
        reset      = 1'b1;
        gray_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {27'd0, w_all}, 64'd0);
        reset    = 1'b0;
        req_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (gray_req) req_seen++;
        end
        check("idle_no_req", req_seen, 0);

        // First window: 9 reads, slot writes lagging one cycle, WRITE on cycle 11.
        gray_ready = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            gray_ready = 1'b0;
            if (c <= 9) begin
                check("full_req", gray_req, 1);
                check("full_addr", gray_addr, exp_full[c-1]);
            end else if (c >= 13 && c <= 15) begin
                check("part_req", gray_req, 1);
                check("part_addr", gray_addr, exp_part[c-13]);
            end else begin
                check("req_low", gray_req, 0);
            end
            if (c >= 2 && c <= 10) begin
                check("full_slot_wr", slot_wr, 1);
                check("full_slot_idx", slot_idx, c - 2);
            end else if (c >= 14 && c <= 16) begin
                check("part_slot_wr", slot_wr, 1);
                check("part_slot_idx", slot_idx, exp_pslot[c-14]);
            end else begin
                check("slot_wr_low", slot_wr, 0);
            end
            check("win_shift", win_shift, (c == 12) ? 1 : 0);
            if (c == 11 || c == 17) begin
                check("lbp_valid", lbp_valid, 1);
                check("lbp_addr", lbp_addr, (c == 11) ? 129 : 130);
            end else begin
                check("lbp_valid_low", lbp_valid, 0);
            end
        end

        // Rest of row 1, then row wrap into a fresh FULL fetch.
        for (int k = 3; k <= 126; k++) begin
            wait_lbp(10, cyc, a);
            check("row1_addr", a, 128 + k);
            check("row1_period", cyc, 6);
        end
        @(negedge clk);
        check("wrap_no_shift", win_shift, 0);
        check("wrap_req", gray_req, 1);
        check("wrap_addr", gray_addr, 128);
        wait_lbp(20, cyc, a);
        check("row2_first_addr", a, 257);
        check("row2_first_lat", cyc, 10);

        // Finish row 2, then reset during the 5th FULL read of row 3.
        for (int k = 2; k <= 126; k++) wait_lbp(10, cyc, a);
        check("row2_last_addr", a, 382);
        repeat (5) @(negedge clk);
        check("row3_read5_addr", gray_addr, 385);
        reset = 1'b1;
        #1;
        check("mid_reset_outs", {27'd0, w_all}, 64'd0);
        @(negedge clk);
        check("mid_reset_hold", {27'd0, w_all}, 64'd0);
        reset    = 1'b0;
        req_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (gray_req) req_seen++;
        end
        check("post_reset_idle", req_seen, 0);

        // Restart and run the whole image.
        npulse = 0; last_lbp_cyc = 0; fin_cyc = -1; first_lbp_cyc = 0; excl = 0;
        first_ga = '1; first_lbp = '1; last_lbp = '1; ga_seen = 1'b0; cyc = 0;
        gray_ready = 1'b1;
        while (!finish && cyc < 100000) begin
            @(negedge clk);
            cyc++;
            gray_ready = 1'b0;
            if (gray_req && !ga_seen) begin
                first_ga = gray_addr;
                ga_seen  = 1'b1;
            end
            if (lbp_valid) begin
                if (npulse == 0) begin
                    first_lbp     = lbp_addr;
                    first_lbp_cyc = cyc;
                end
                npulse++;
                last_lbp     = lbp_addr;
                last_lbp_cyc = cyc;
            end
            if ($countones({win_shift, lbp_valid, gray_req | slot_wr}) > 1) excl++;
            if (finish) fin_cyc = cyc;
        end
        check("run_finish", finish, 1);
        check("restart_first_gaddr", first_ga, 0);
        check("restart_first_lbp", first_lbp, 129);
        check("restart_first_lat", first_lbp_cyc, 11);
        check("lbp_pulses", npulse, 15876);
        check("last_lbp_addr", last_lbp, 16254);
        check("finish_timing", fin_cyc, last_lbp_cyc + 1);
        check("strobe_exclusive", excl, 0);

        // DONE holds finish and ignores gray_ready.
        gray_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("done_hold", {27'd0, w_all}, 64'd1);
        gray_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
